// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: icache request/response, backend redirect and the
// decode-side instruction stream.
//   master : fetch unit side (drives icache request and decode stream)
//   slave  : environment side (icache, backend, decode)
interface fetch_unit_if;
  logic        icache_rqst;
  logic [63:0] icache_addr;
  logic        icache_done;
  logic [63:0] icache_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;

  modport master (
    output icache_rqst, icache_addr, inst_valid, inst_data, inst_pc,
    input  icache_done, icache_data, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  icache_rqst, icache_addr, inst_valid, inst_data, inst_pc,
    output icache_done, icache_data, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the fetch PC, issues one 32-bit icache
// request at a time (rqst held until done), buffers returned instructions
// with their PCs in a small FIFO and presents the head to decode over
// valid/ready. Backend redirects flush the buffer and restart fetch.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-low reset
//   bus  - fetch_unit_if.master: icache_rqst/addr/done/data,
//          redirect_valid/pc, inst_valid/ready/data/pc
module fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h400000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, FLUSH} state_t;

  state_t        r_state, w_state_nxt;
  logic [63:0]   r_fetch_pc, w_fetch_pc_nxt;
  logic [63:0]   r_req_addr, w_req_addr_nxt;

  logic [63:0]   r_mem_pc   [FIFO_DEPTH];
  logic [31:0]   r_mem_inst [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;

  logic          w_redir;
  logic [63:0]   w_redir_pc;
  logic          w_done;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_after;
  logic          w_space;
  logic          w_unused_bits;

  assign w_redir    = bus.redirect_valid;
  assign w_redir_pc = {bus.redirect_pc[63:2], 2'b00};
  // done is only meaningful while a request is outstanding
  assign w_done     = bus.icache_done & (r_state != IDLE);
  assign w_push     = w_done & (r_state == WAIT) & ~w_redir;
  assign w_pop      = (r_count != '0) & bus.inst_ready;

  // Occupancy after this cycle's traffic; decides whether another request
  // may be launched without risking an overflow.
  assign w_count_after = r_count + CW'(w_push) - CW'(w_pop);
  assign w_space       = w_count_after < CW'(FIFO_DEPTH);

  assign w_unused_bits = ^{bus.icache_data[63:32], bus.redirect_pc[1:0]};

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_addr_nxt = r_req_addr;
    unique case (r_state)
      IDLE: begin
        if (w_redir) begin
          w_state_nxt    = WAIT;
          w_req_addr_nxt = w_redir_pc;
        end else if (w_space) begin
          w_state_nxt    = WAIT;
          w_req_addr_nxt = r_fetch_pc;
        end
      end
      WAIT: begin
        if (w_redir) begin
          // Address must stay stable until the outstanding request completes
          if (w_done) begin
            w_state_nxt    = WAIT;
            w_req_addr_nxt = w_redir_pc;
          end else begin
            w_state_nxt    = FLUSH;
          end
        end else if (w_done) begin
          if (w_space) begin
            w_req_addr_nxt = r_req_addr + 64'd4;
            w_fetch_pc_nxt = r_req_addr + 64'd8;
          end else begin
            w_state_nxt    = IDLE;
            w_fetch_pc_nxt = r_req_addr + 64'd4;
          end
        end
      end
      FLUSH: begin
        if (w_done) begin
          if (w_redir) begin
            w_state_nxt    = WAIT;
            w_req_addr_nxt = w_redir_pc;
          end else if (w_space) begin
            w_state_nxt    = WAIT;
            w_req_addr_nxt = r_fetch_pc;
          end else begin
            w_state_nxt    = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_redir) begin
      w_fetch_pc_nxt = w_redir_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_addr <= w_req_addr_nxt;
    end
  end

  // Instruction buffer; a redirect empties it and overrides any pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_pc[i]   <= '0;
        r_mem_inst[i] <= '0;
      end
    end else if (w_redir) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem_pc[r_wptr]   <= r_req_addr;
        r_mem_inst[r_wptr] <= bus.icache_data[31:0];
        r_wptr             <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_count <= w_count_after;
    end
  end

  assign bus.icache_rqst = (r_state != IDLE);
  assign bus.icache_addr = r_req_addr;
  assign bus.inst_valid  = (r_count != '0);
  assign bus.inst_data   = r_mem_inst[r_rptr];
  assign bus.inst_pc     = r_mem_pc[r_rptr];

endmodule
